uart_packet_parser: RTL
=======================

Name: uart_packet_parser

Overview:
Sits between the UART receiver and the ALU. Consumes the received byte stream and parses each command packet: opcode, reserved byte, 16-bit little-endian length, then payload. Hands the ALU a stable opcode plus a ready/valid stream of 33-bit operand words, each tagged with first/last flags. Drains and flags malformed packets so the ALU never sees a bad packet.

Parameters:
- MAX_LEN, 16'hFFFF: largest accepted total packet length in bytes (header included); anything larger is drained and flagged.
- TIMEOUT_CYCLES, 24'd1_200_000: inter-byte timeout in clk cycles (used only with PARSER_TIMEOUT_EN).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- rx_data_i  input  8  received byte
- rx_valid_i  input  1  rx_data_i valid
- rx_ready_o  output  1  parser accepts a byte (handshake when rx_valid_i & rx_ready_o)
- opcode_o  output  8  opcode of the current packet, to ALU opcode_i
- data_o  output  33  operand word; bit 32 is always 0
- first_o  output  1  data_o is the first word of the packet (drives ALU state_start_i)
- last_o  output  1  data_o is the last word of the packet
- valid_o  output  1  data_o/first_o/last_o valid
- ready_i  input  1  ALU accepts the word
- err_o  output  1  one-cycle pulse: packet was rejected
- busy_o  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE. Outputs: opcode_o=0, data_o=0, first_o=0, last_o=0, valid_o=0, err_o=0, busy_o=0. Any partial word and byte count are discarded. rx_ready_o=1 after release.
- States: IDLE(opcode) -> RSVD -> LEN_LO -> LEN_HI -> PAYLOAD <-> EMIT; DRAIN. Each transition out of IDLE/RSVD/LEN_LO/LEN_HI/PAYLOAD/DRAIN happens only on an rx handshake.
- rx_ready_o=1 in every state except EMIT.
- opcode_o is latched on the IDLE handshake. It stays stable until the next packet's opcode byte is accepted.
- Validation, on the LEN_HI handshake, with L={hi,lo}:
  - Valid when 4<=L<=MAX_LEN and:
    - EC: any L.
    - AD/AC: L>=8 and (L-4)%4==0.
    - D1: L==12.
  - Otherwise: enter DRAIN, discard max(L-4,0) bytes, then return to IDLE with err_o pulsed the cycle after the final drained byte.
  - For L<4, err_o pulses the cycle after LEN_HI and the state returns to IDLE.
  - For a valid EC packet with L==4: return to IDLE; no words, no error.
- PAYLOAD packing:
  - AD/AC/D1: 4 bytes packed little-endian (first byte -> bits 7:0) into one word.
  - EC: each byte is its own word, zero-extended.
- A word completes on the handshake of its final byte. The state moves to EMIT and valid_o=1 on the next cycle (latency 1).
- first_o is 1 only for word 0. last_o is 1 when the remaining payload count reaches 0.
- EMIT: data_o/first_o/last_o/valid_o are held stable until ready_i=1.
  - On the accepting cycle, valid_o drops next cycle.
  - The state returns to PAYLOAD, or to IDLE if last_o.
  - No byte is accepted while in EMIT (backpressure to the UART).
- ready_i is ignored while valid_o=0.
- Byte counter is 16-bit. It is loaded with L-4 and decremented per payload/drain byte, with no wrap.
- Reset mid-packet or mid-EMIT: valid_o drops immediately (async). The next byte after release is treated as an opcode.

Optional Feature:
PARSER_TIMEOUT_EN
- Defined:
  - A 24-bit counter runs in RSVD/LEN_LO/LEN_HI/PAYLOAD/DRAIN. It clears on every rx handshake and on entry to these states, and it holds in EMIT.
  - When it reaches TIMEOUT_CYCLES: state -> IDLE, partial word discarded, err_o pulses 1 cycle.
- Undefined: no counter. The parser waits indefinitely for the next byte.

Test Plan:
- Reset release then bytes AD 00 0C 00 01 00 00 00 02 00 00 00, ready_i=1 -> words 0x000000001 (first=1, last=0) and 0x000000002 (first=0, last=1), opcode_o=AD, err_o never high.
- EC 00 06 00 41 42, ready_i held 0 for 5 cycles -> word 0x041 held stable with valid_o=1 and rx_ready_o=0 throughout; after accept, word 0x042 with last=1.
- D1 00 08 00 05 00 00 00 -> DRAIN of 4 bytes, err_o single pulse, no valid_o; next packet EC 00 04 00 parses cleanly with no output and no error.
- Opcode 0x55, length 0x0006, 2 payload bytes -> drained, err_o pulse; opcode_o=0x55 but valid_o stays 0.
- rst asserted after 5 bytes of an AD packet -> outputs zero immediately; after release, a fresh AC 00 08 00 03 00 00 00 yields word 0x000000003 with first=1, last=1.
- With PARSER_TIMEOUT_EN and TIMEOUT_CYCLES=100: send AD 00, then idle 100 cycles -> err_o pulse, busy_o=0; without the macro, busy_o stays 1.

Source files
------------

// File: rtl/uart_packet_parser.sv
// Purpose: parses UART command packets (opcode, rsvd, 16-bit LE length, payload) into 33-bit ALU operand words; malformed packets are drained and flagged.
// Latency: an operand word is presented (valid_o) one cycle after the handshake of its final payload byte.
// Backpressure: rx_ready_o drops while a word waits in EMIT; ready_i is honoured only while valid_o is high.
// Optional: define PARSER_TIMEOUT_EN to abort a packet after TIMEOUT_CYCLES idle cycles between bytes.
module uart_packet_parser #(
  parameter logic [15:0] MAX_LEN        = 16'hFFFF,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_200_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  opcode_o,
  output logic [32:0] data_o,
  output logic        first_o,
  output logic        last_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        err_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_RSVD, S_LEN_LO, S_LEN_HI, S_PAYLOAD, S_EMIT, S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  len_lo_q;
  logic [15:0] cnt_q;
  logic [31:0] word_q;
  logic [1:0]  byte_idx_q;
  logic        first_pend_q;
  logic        err_set;
  logic        tmo_hit;

  logic        rx_hs;
  logic [15:0] len;
  logic        len_ok;
  logic        is_ec, is_word_op;
  logic        word_done;
  logic [15:0] cnt_dec;
  logic [31:0] word_next;

  assign rx_ready_o = (state_q != S_EMIT);
  assign busy_o     = (state_q != S_IDLE);
  assign rx_hs      = rx_valid_i & rx_ready_o;

  assign len        = {rx_data_i, len_lo_q};
  assign is_ec      = (opcode_o == 8'hEC);
  assign is_word_op = (opcode_o == 8'hAD) || (opcode_o == 8'hAC);
  // (L-4) % 4 == 0 is the same as L % 4 == 0
  assign len_ok     = (len >= 16'd4) && (len <= MAX_LEN) &&
                      (is_ec ||
                       (is_word_op && (len >= 16'd8) && (len[1:0] == 2'b00)) ||
                       ((opcode_o == 8'hD1) && (len == 16'd12)));
  assign cnt_dec    = (cnt_q != 16'd0) ? cnt_q - 16'd1 : 16'd0;
  assign word_done  = (state_q == S_PAYLOAD) && rx_hs && (is_ec || (byte_idx_q == 2'd3));

  // Byte placement: EC bytes stand alone, others land little-endian by position
  always_comb begin
    word_next = word_q;
    if (is_ec) begin
      word_next = {24'd0, rx_data_i};
    end else begin
      word_next[byte_idx_q*8 +: 8] = rx_data_i;
    end
  end

`ifdef PARSER_TIMEOUT_EN
  logic [23:0] tmo_cnt_q;
  logic        tmo_counting;

  assign tmo_counting = (state_q == S_RSVD) || (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                        (state_q == S_PAYLOAD) || (state_q == S_DRAIN);
  assign tmo_hit      = tmo_counting && !rx_hs && (tmo_cnt_q == TIMEOUT_CYCLES);

  // Inter-byte idle counter: cleared by traffic or a state change, frozen in EMIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= 24'd0;
    end else if ((state_d != state_q) || rx_hs) begin
      tmo_cnt_q <= 24'd0;
    end else if (tmo_counting) begin
      tmo_cnt_q <= tmo_cnt_q + 24'd1;
    end
  end
`else
  // No idle abort in this build; the parameter only matters with the timeout enabled
  assign tmo_hit = (TIMEOUT_CYCLES == 24'd0) & 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state decode and reject detection
  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    case (state_q)
      S_IDLE:   if (rx_hs) state_d = S_RSVD;
      S_RSVD:   if (rx_hs) state_d = S_LEN_LO;
      S_LEN_LO: if (rx_hs) state_d = S_LEN_HI;
      S_LEN_HI: begin
        if (rx_hs) begin
          if (len_ok) begin
            state_d = (len == 16'd4) ? S_IDLE : S_PAYLOAD;
          end else if (len <= 16'd4) begin
            // nothing to drain, reject right away
            state_d = S_IDLE;
            err_set = 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_PAYLOAD: if (word_done) state_d = S_EMIT;
      S_EMIT:    if (ready_i) state_d = last_o ? S_IDLE : S_PAYLOAD;
      S_DRAIN: begin
        if (rx_hs && (cnt_q <= 16'd1)) begin
          state_d = S_IDLE;
          err_set = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (tmo_hit) begin
      state_d = S_IDLE;
      err_set = 1'b1;
    end
  end

  // Header capture, payload packing, byte counting and the output word register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opcode_o     <= 8'd0;
      len_lo_q     <= 8'd0;
      cnt_q        <= 16'd0;
      word_q       <= 32'd0;
      byte_idx_q   <= 2'd0;
      first_pend_q <= 1'b0;
      data_o       <= 33'd0;
      first_o      <= 1'b0;
      last_o       <= 1'b0;
      valid_o      <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      err_o <= err_set;
      case (state_q)
        S_IDLE: begin
          if (rx_hs) begin
            opcode_o     <= rx_data_i;
            first_pend_q <= 1'b1;
            byte_idx_q   <= 2'd0;
            word_q       <= 32'd0;
          end
        end
        S_LEN_LO: if (rx_hs) len_lo_q <= rx_data_i;
        S_LEN_HI: if (rx_hs) cnt_q <= (len >= 16'd4) ? len - 16'd4 : 16'd0;
        S_PAYLOAD: begin
          if (rx_hs) begin
            word_q     <= word_next;
            byte_idx_q <= byte_idx_q + 2'd1;
            cnt_q      <= cnt_dec;
            if (word_done) begin
              data_o       <= {1'b0, word_next};
              first_o      <= first_pend_q;
              last_o       <= (cnt_dec == 16'd0);
              valid_o      <= 1'b1;
              first_pend_q <= 1'b0;
              byte_idx_q   <= 2'd0;
            end
          end
        end
        S_EMIT:  if (ready_i) valid_o <= 1'b0;
        S_DRAIN: if (rx_hs) cnt_q <= cnt_dec;
        default: ;
      endcase
      if (tmo_hit) begin
        word_q     <= 32'd0;
        byte_idx_q <= 2'd0;
      end
    end
  end

endmodule
